// File: rtl/piso_fifo_tx_pkg.sv
// Shared types and width helpers for the parallel-in serial-out transmitter.
package piso_fifo_tx_pkg;

  // Shift engine states.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // Pointer width for a word FIFO of the given depth (PTR_W).
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Bit counter width for a word of the given width (CNT_W).
  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_fifo_tx_fifo.sv
// Show-ahead synchronous word FIFO with an exact occupancy count.
module sync_word_fifo
  import piso_fifo_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [ptr_w(DEPTH):0]    level
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             do_push, do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Word storage; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  // Pointers wrap naturally; level tracks the exact number of held words.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);
  assign level = level_q;

endmodule

// File: rtl/piso_fifo_tx.sv
// Parallel-in serial-out transmitter: word FIFO feeding a framed bit shifter.
module piso_fifo_tx
  import piso_fifo_tx_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WIDTH-1:0]        datain,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic                    dataout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    frame_start,
  output logic                    frame_end,
  output logic [ptr_w(DEPTH):0]   level
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             fs_q, fs_d;
  logic             fe_q, fe_d;

  // in_ready depends only on the registered level, so a pop cannot free a slot early.
  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;

  sync_word_fifo #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (datain),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Shift engine next state, head-word loading and registered output values.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    fifo_pop = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_rdata;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        if (valid_q && out_ready) begin
          if (cnt_q == LAST_BIT) begin
            cnt_d = '0;
            if (!fifo_empty) begin
              // Load the next word on the same edge so words run back to back.
              fifo_pop = 1'b1;
              shift_d  = fifo_rdata;
            end else begin
              shift_d = '0;
              state_d = IDLE;
            end
          end else begin
            cnt_d   = cnt_q + 1'b1;
            shift_d = (MSB_FIRST != 0) ? (shift_q << 1) : (shift_q >> 1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == SHIFT);
    dout_d  = valid_d && ((MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0]);
    fs_d    = valid_d && (cnt_d == '0);
    fe_d    = valid_d && (cnt_d == LAST_BIT);
  end

  // State, shifter and output registers; reset discards any partially sent word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      fs_q    <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      fs_q    <= fs_d;
      fe_q    <= fe_d;
    end
  end

  assign dataout     = dout_q;
  assign out_valid   = valid_q;
  assign frame_start = fs_q;
  assign frame_end   = fe_q;

endmodule

// File: tb/tb_piso_fifo_tx.sv
// Scoreboard bench: an MSB-first and an LSB-first instance share all stimulus.
module tb_piso_fifo_tx;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int LW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [W-1:0]  datain;
  logic          in_valid, out_ready;
  logic [1:0]    in_ready_v, dataout_v, out_valid_v, fs_v, fe_v;
  logic [LW-1:0] level0, level1;

  piso_fifo_tx #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1)) u_msb (
    .clk(clk), .rst_n(rst_n), .datain(datain), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .dataout(dataout_v[0]), .out_valid(out_valid_v[0]),
    .out_ready(out_ready), .frame_start(fs_v[0]), .frame_end(fe_v[0]), .level(level0)
  );

  piso_fifo_tx #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .datain(datain), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .dataout(dataout_v[1]), .out_valid(out_valid_v[1]),
    .out_ready(out_ready), .frame_start(fs_v[1]), .frame_end(fe_v[1]), .level(level1)
  );

  int total = 0;
  int bad   = 0;

  // Expected serial symbols, packed as {frame_end, frame_start, bit}.
  logic [2:0] exp_q0[$];
  logic [2:0] exp_q1[$];

  int max_run, run_len, max_lvl, full_cycles, bits_seen;
  logic [1:0] hold_p;
  logic [2:0] prev_out [2];

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s inst%0d: got %0h want %0h at %0t", name, k, act, exp, $time);
    end
  endtask

  // Reference: the i-th symbol sent for word w.
  function automatic logic [2:0] sym_of(input logic [W-1:0] w, input int i, input bit msb);
    logic b;
    b = msb ? w[W-1-i] : w[i];
    return {(i == W-1), (i == 0), b};
  endfunction

  // Monitor: per-cycle checks and scoreboard pops, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold_p  = '0;
      run_len = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic [LW-1:0] lv;
        logic [2:0]    got, e;
        lv  = (k == 0) ? level0 : level1;
        got = {fe_v[k], fs_v[k], dataout_v[k]};
        chk("in_ready_vs_level", k, in_ready_v[k], (lv != LW'(D)));
        chk("level_range", k, (lv <= LW'(D)), 1);
        if (hold_p[k]) begin
          chk("hold_valid", k, out_valid_v[k], 1);
          chk("hold_symbol", k, got, prev_out[k]);
        end
        if (!out_valid_v[k]) chk("idle_outputs", k, got, 0);
        if (out_valid_v[k] && out_ready) begin
          if ((k == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_bit inst%0d: got %0h want none at %0t", k, got, $time);
          end else begin
            e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("serial_symbol", k, got, e);
          end
        end
        if (in_valid && in_ready_v[k]) begin
          for (int i = 0; i < W; i++) begin
            if (k == 0) exp_q0.push_back(sym_of(datain, i, 1'b1));
            else        exp_q1.push_back(sym_of(datain, i, 1'b0));
          end
        end
        hold_p[k]   = out_valid_v[k] && !out_ready;
        prev_out[k] = got;
      end
      if (int'(level0) > max_lvl) max_lvl = int'(level0);
      if (!in_ready_v[0]) full_cycles++;
      if (out_valid_v[0] && out_ready) begin
        run_len++;
        bits_seen++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  // Present a word and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic push_word(input logic [W-1:0] w);
    int n;
    n = 0;
    datain   = w;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready_v[0] && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) chk("push_timeout", 0, in_ready_v[0], 1);
    @(posedge clk);
    #1;
  endtask

  // Wait for every expected bit to leave both instances.
  task automatic wait_drain();
    int n;
    n = 0;
    while (((exp_q0.size() + exp_q1.size()) != 0 || out_valid_v != 2'b00) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_left", 0, exp_q0.size() + exp_q1.size(), 0);
    chk("drain_idle", 0, out_valid_v, 0);
  endtask

  logic [W-1:0] b2b [6] = '{8'h01, 8'h80, 8'hFF, 8'h3C, 8'hC3, 8'h5A};

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; datain = '0; out_ready = 1'b0;
    max_run = 0; run_len = 0; max_lvl = 0; full_cycles = 0; bits_seen = 0;
    hold_p = '0;
    #2 rst_n = 1'b0;

    // Reset with random inputs
    repeat (5) begin
      @(posedge clk); #1;
      in_valid = 1'($urandom); datain = W'($urandom); out_ready = 1'($urandom);
      @(negedge clk);
      chk("reset_in_ready", 0, in_ready_v, 2'b11);
      chk("reset_out_valid", 0, out_valid_v, 0);
      chk("reset_dataout", 0, dataout_v, 0);
      chk("reset_flags", 0, {fs_v, fe_v}, 0);
      chk("reset_level", 0, {level0, level1}, 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single word with latency and framing
    push_word(8'hA5);
    in_valid = 1'b0;
    @(negedge clk);
    chk("latency_not_early", 0, out_valid_v, 0);
    @(negedge clk);
    chk("first_bit_valid", 0, out_valid_v, 2'b11);
    chk("first_bit_start", 0, fs_v, 2'b11);
    repeat (8) @(negedge clk);
    chk("valid_drops_after_word", 0, out_valid_v, 0);
    @(posedge clk); #1;

    // Back-to-back until full, then one more push held off
    max_run = 0; max_lvl = 0; full_cycles = 0;
    for (int i = 0; i < 6; i++) push_word(b2b[i]);
    in_valid = 1'b0;
    wait_drain();
    chk("level_peak", 0, max_lvl, D);
    chk("in_ready_dropped", 0, (full_cycles > 0), 1);
    chk("contiguous_bits", 0, max_run, 6 * W);

    // Backpressure for 3 cycles on bit 4
    push_word(8'h96);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_drain();

    // Reset in the middle of a word with two more queued
    push_word(8'hF0);
    push_word(8'h11);
    push_word(8'h22);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_busy", 0, out_valid_v, 2'b11);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    chk("async_clear_valid", 0, out_valid_v, 0);
    chk("async_clear_data", 0, {dataout_v, fs_v, fe_v}, 0);
    chk("async_clear_level", 0, {level0, level1}, 0);
    chk("async_clear_ready", 0, in_ready_v, 2'b11);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bits_seen = 0;
    push_word(8'h55);
    in_valid = 1'b0;
    wait_drain();
    repeat (5) @(posedge clk);
    #1;
    chk("post_reset_bits", 0, bits_seen, W);

    // Randomized traffic with random backpressure
    repeat (300) begin
      in_valid  = ($urandom_range(0, 9) < 6);
      datain    = W'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
